time_of_day_counter: RTL and testbench

- Free-running wall-clock counter: seconds, minutes and hours (0-23), advanced by a one-cycle tick pulse.
- Sits directly upstream of the hour-to-day/night decoder; `hours_out` is its 5-bit hour input.
- Also supplies hour-change and midnight-rollover strobes to the light controller.
- Supports a validated load of hour/minute by the operator/test interface.

---
 rtl/time_of_day_counter.sv | 137 +++++++++++++
 tb/tb_time_of_day_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// ----------------------------------------------------------------------------
// time_of_day_counter
//
// Free-running wall clock (hh:mm:ss, 24-hour) advanced by a tick pulse, with
// an optional prescaler so several ticks make up one counted second. An
// operator load sets hour/minute and is validated before it is applied.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   tick_in      single-cycle advance pulse
//   set_valid    load request, level-sampled every rising edge
//   set_hour     hour to load, legal 0-23
//   set_minute   minute to load, legal 0-59
//   hours_out    current hour 0-23
//   minutes_out  current minute 0-59
//   seconds_out  current second 0-59
//   hour_strobe  one-cycle pulse when hours_out changes value
//   day_rollover one-cycle pulse when hours wraps 23->0 by counting
//   set_error    one-cycle pulse when a load request is rejected
//
// Parameters:
//   RESET_HOUR       hour loaded on reset, 0-23
//   RESET_MINUTE     minute loaded on reset, 0-59
//   TICKS_PER_SECOND tick_in pulses per counted second, 1-255
// ----------------------------------------------------------------------------
module time_of_day_counter #(
    parameter int RESET_HOUR       = 0,
    parameter int RESET_MINUTE     = 0,
    parameter int TICKS_PER_SECOND = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_minute,
    output logic [4:0] hours_out,
    output logic [5:0] minutes_out,
    output logic [5:0] seconds_out,
    output logic       hour_strobe,
    output logic       day_rollover,
    output logic       set_error
);

    localparam logic [4:0] LAST_HOUR   = 5'd23;
    localparam logic [5:0] LAST_MINSEC = 6'd59;
    localparam logic [7:0] PRESC_LAST  = 8'(TICKS_PER_SECOND - 1);
    localparam logic [4:0] INIT_HOUR   = 5'(RESET_HOUR);
    localparam logic [5:0] INIT_MINUTE = 6'(RESET_MINUTE);

    logic [7:0] presc;
    logic [7:0] presc_nxt;
    logic [4:0] hours_nxt;
    logic [5:0] minutes_nxt;
    logic [5:0] seconds_nxt;
    logic       hour_strobe_nxt;
    logic       day_rollover_nxt;
    logic       set_error_nxt;
    logic       set_legal;

    assign set_legal = (set_hour <= LAST_HOUR) && (set_minute <= LAST_MINSEC);

    // Next-state logic. Priority: load (accepted or rejected) over tick, so
    // any load request freezes the prescaler and the time for that cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        hours_nxt        = hours_out;
        minutes_nxt      = minutes_out;
        seconds_nxt      = seconds_out;
        presc_nxt        = presc;
        hour_strobe_nxt  = 1'b0;
        day_rollover_nxt = 1'b0;
        set_error_nxt    = 1'b0;

        if (set_valid) begin
            if (set_legal) begin
                hours_nxt       = set_hour;
                minutes_nxt     = set_minute;
                seconds_nxt     = '0;
                presc_nxt       = '0;
                hour_strobe_nxt = (set_hour != hours_out);
            end else begin
                set_error_nxt = 1'b1;
            end
        end else if (tick_in) begin
            if (presc == PRESC_LAST) begin
                presc_nxt = '0;
                // Second-advance cascade: seconds -> minutes -> hours.
                if (seconds_out == LAST_MINSEC) begin
                    seconds_nxt = '0;
                    if (minutes_out == LAST_MINSEC) begin
                        minutes_nxt     = '0;
                        hour_strobe_nxt = 1'b1;
                        if (hours_out == LAST_HOUR) begin
                            hours_nxt        = '0;
                            day_rollover_nxt = 1'b1;
                        end else begin
                            hours_nxt = hours_out + 5'd1;
                        end
                    end else begin
                        minutes_nxt = minutes_out + 6'd1;
                    end
                end else begin
                    seconds_nxt = seconds_out + 6'd1;
                end
            end else begin
                presc_nxt = presc + 8'd1;
            end
        end
    end

    // All outputs are registered; reset wins over load and tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            hours_out    <= INIT_HOUR;
            minutes_out  <= INIT_MINUTE;
            seconds_out  <= '0;
            presc        <= '0;
            hour_strobe  <= 1'b0;
            day_rollover <= 1'b0;
            set_error    <= 1'b0;
        end else begin
            hours_out    <= hours_nxt;
            minutes_out  <= minutes_nxt;
            seconds_out  <= seconds_nxt;
            presc        <= presc_nxt;
            hour_strobe  <= hour_strobe_nxt;
            day_rollover <= day_rollover_nxt;
            set_error    <= set_error_nxt;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// ----------------------------------------------------------------------------
// tb_time_of_day_counter
//
// Two instances share one stimulus stream: one with one tick per second and
// one with four ticks per second. Each has a reference model that keeps time
// as seconds-since-midnight plus a tick count, and a compare process checks
// every output of both instances on every falling edge. Directed phases pin
// the model with hand-computed literal values; a random phase follows.
// ----------------------------------------------------------------------------
module tb_time_of_day_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_minute = '0;

    logic [4:0] h0, h1;
    logic [5:0] m0, m1, s0, s1;
    logic       hs0, hs1, dr0, dr1, se0, se1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    time_of_day_counter dut0 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .set_valid(set_valid),
        .set_hour(set_hour), .set_minute(set_minute),
        .hours_out(h0), .minutes_out(m0), .seconds_out(s0),
        .hour_strobe(hs0), .day_rollover(dr0), .set_error(se0)
    );

    time_of_day_counter #(.TICKS_PER_SECOND(4)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .set_valid(set_valid),
        .set_hour(set_hour), .set_minute(set_minute),
        .hours_out(h1), .minutes_out(m1), .seconds_out(s1),
        .hour_strobe(hs1), .day_rollover(dr1), .set_error(se1)
    );

    // Reference model: time of day in seconds, ticks pending toward a second.
    int tps [2] = '{1, 4};
    int t_sec [2];
    int t_pre [2];
    bit e_hs [2];
    bit e_dr [2];
    bit e_se [2];
    bit model_ok = 1'b0;

    task automatic model_step(input int i);
        int old_t;
        old_t = t_sec[i];
        e_hs[i] = 1'b0;
        e_dr[i] = 1'b0;
        e_se[i] = 1'b0;
        if (rst) begin
            t_sec[i] = 0;
            t_pre[i] = 0;
        end else if (set_valid) begin
            if (int'(set_hour) < 24 && int'(set_minute) < 60) begin
                t_sec[i] = int'(set_hour) * 3600 + int'(set_minute) * 60;
                t_pre[i] = 0;
                e_hs[i]  = (t_sec[i] / 3600) != (old_t / 3600);
            end else begin
                e_se[i] = 1'b1;
            end
        end else if (tick_in) begin
            t_pre[i] = t_pre[i] + 1;
            if (t_pre[i] == tps[i]) begin
                t_pre[i] = 0;
                t_sec[i] = (t_sec[i] + 1) % 86400;
                e_hs[i]  = (t_sec[i] / 3600) != (old_t / 3600);
                e_dr[i]  = (t_sec[i] == 0);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) model_ok <= 1'b1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("d0.hours",   int'(h0),  t_sec[0] / 3600);
            check("d0.minutes", int'(m0),  (t_sec[0] / 60) % 60);
            check("d0.seconds", int'(s0),  t_sec[0] % 60);
            check("d0.hour_strobe",  int'(hs0), int'(e_hs[0]));
            check("d0.day_rollover", int'(dr0), int'(e_dr[0]));
            check("d0.set_error",    int'(se0), int'(e_se[0]));
            check("d1.hours",   int'(h1),  t_sec[1] / 3600);
            check("d1.minutes", int'(m1),  (t_sec[1] / 60) % 60);
            check("d1.seconds", int'(s1),  t_sec[1] % 60);
            check("d1.hour_strobe",  int'(hs1), int'(e_hs[1]));
            check("d1.day_rollover", int'(dr1), int'(e_dr[1]));
            check("d1.set_error",    int'(se1), int'(e_se[1]));
        end
    end

    // One clock cycle with the given inputs; returns #1 after the edge with
    // inputs back to idle so the new register values can be sampled.
    task automatic step(input bit tk, input bit sv, input int hr, input int mn, input bit r);
        tick_in    = tk;
        set_valid  = sv;
        set_hour   = 5'(hr);
        set_minute = 6'(mn);
        rst        = r;
        @(posedge clk);
        #1;
        tick_in   = 1'b0;
        set_valid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic check_time0(input string name, input int hr, input int mn, input int sc);
        check({name, ".h"}, int'(h0), hr);
        check({name, ".m"}, int'(m0), mn);
        check({name, ".s"}, int'(s0), sc);
    endtask

    task automatic check_time1(input string name, input int hr, input int mn, input int sc);
        check({name, ".h"}, int'(h1), hr);
        check({name, ".m"}, int'(m1), mn);
        check({name, ".s"}, int'(s1), sc);
    endtask

    initial begin
        int hs_count;
        int dr_count;

        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_time0("reset.d0", 0, 0, 0);
        check("reset.strobes", int'({hs0, dr0, se0, hs1, dr1, se1}), 0);

        // 3600 ticks: one hour on d0, 15 minutes on d1
        hs_count = 0;
        dr_count = 0;
        for (int i = 0; i < 3600; i++) begin
            step(1, 0, 0, 0, 0);
            hs_count += int'(hs0);
            dr_count += int'(dr0);
            if (i == 3599) check("hour.strobe_on_last", int'(hs0), 1);
        end
        step(0, 0, 0, 0, 0);
        check_time0("hour.d0", 1, 0, 0);
        check_time1("hour.d1", 0, 15, 0);
        check("hour.strobe_count", hs_count, 1);
        check("hour.rollover_count", dr_count, 0);

        // Load 23:59, then 60 ticks wraps to midnight
        step(0, 1, 23, 59, 0);
        check("load2359.hour_strobe", int'(hs0), 1);
        check("load2359.rollover", int'(dr0), 0);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 0);
        check_time0("midnight.d0", 0, 0, 0);
        check("midnight.hour_strobe", int'(hs0), 1);
        check("midnight.rollover", int'(dr0), 1);
        check_time1("midnight.d1", 23, 59, 15);
        step(0, 0, 0, 0, 0);
        check("midnight.rollover_one_cycle", int'(dr0), 0);

        // Rejected loads, with and without a coincident tick
        step(1, 0, 0, 0, 0);
        step(0, 1, 24, 0, 0);
        check("err_hour.set_error", int'(se0), 1);
        check_time0("err_hour.d0", 0, 0, 1);
        step(1, 1, 3, 60, 0);
        check("err_min.set_error", int'(se0), 1);
        check_time0("err_min.d0", 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("err.one_cycle", int'(se0), 0);

        // Load with coincident tick: tick dropped
        step(1, 1, 5, 30, 0);
        check_time0("load0530.d0", 5, 30, 0);
        step(1, 0, 0, 0, 0);
        check_time0("load0530_tick.d0", 5, 30, 1);

        // Four ticks per second: 7 ticks -> 1 s, reload clears prescaler
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        check_time1("tps4_7.d1", 0, 0, 1);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check_time1("tps4_reload3.d1", 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_time1("tps4_reload4.d1", 0, 0, 1);

        // Reset at 12:34:56 with a coincident tick
        step(0, 1, 12, 34, 0);
        for (int i = 0; i < 56; i++) step(1, 0, 0, 0, 0);
        check_time0("pre_reset.d0", 12, 34, 56);
        step(1, 1, 7, 7, 1);
        check_time0("mid_reset.d0", 0, 0, 0);
        check("mid_reset.strobes", int'({hs0, dr0, se0}), 0);

        // Random phase, checked every cycle by the compare process
        for (int i = 0; i < 6000; i++) begin
            int r;
            bit tk, sv, rs;
            int hr, mn;
            r  = int'($urandom_range(999));
            tk = ($urandom_range(9) < 7);
            sv = (r < 30);
            rs = (r >= 996);
            if ($urandom_range(3) == 0) begin
                hr = int'($urandom_range(31));
                mn = int'($urandom_range(63));
            end else if ($urandom_range(1) == 0) begin
                hr = 23;
                mn = 58 + int'($urandom_range(1));
            end else begin
                hr = int'($urandom_range(23));
                mn = 55 + int'($urandom_range(4));
            end
            step(tk, sv, hr, mn, rs);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
